exp_preprocess_pipe: RTL and testbench

EXP_PREPROCESS_PIPE -- requirements
Module: exp_preprocess_pipe

---
 rtl/exp_preprocess_pipe_pkg.sv | 13 +
 rtl/exp_preproc_lane.sv | 58 +++++
 rtl/exp_preprocess_pipe.sv | 85 ++++++++
 tb/tb_exp_preprocess_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_preprocess_pipe_pkg.sv
// Shared mode encodings and default widths for the exp pre-processing pipeline.
package exp_preprocess_pipe_pkg;

    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int FIXPOINT_FRAC       = 10;

    typedef enum logic [1:0] {
        MODE_X   = 2'b00,
        MODE_ADD = 2'b01,
        MODE_SUB = 2'b10
    } mode_e;

endpackage

// File: rtl/exp_preproc_lane.sv
// One lane of the exp pre-processor: aligned add on the input side, and
// constant multiply by 1.0111b plus integer/fraction split on the registered side.
// Optional saturation of the integer result: EXP_PREPROC_SAT_EN.
module exp_preproc_lane
    import exp_preprocess_pipe_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC,
    parameter int W      = DATA_W + FRAC_W + 2
) (
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   lnf,
    input  logic [1:0]          mode,
    output logic signed [W-1:0] a,
    input  logic signed [W-1:0] a_q,
    output logic [DATA_W-1:0]   u,
    output logic [FRAC_W-1:0]   v,
    output logic                ovf
);

    logic signed [W-1:0] x_al;
    logic signed [W-1:0] lnf_ext;
    logic signed [W-1:0] y;
    logic [W-FRAC_W-1:0] y_int;

    always_comb begin
        x_al    = {{(W-DATA_W-FRAC_W){x[DATA_W-1]}}, x, {FRAC_W{1'b0}}};
        lnf_ext = {{(W-DATA_W){lnf[DATA_W-1]}}, lnf};
        case (mode)
            MODE_ADD: a = x_al + lnf_ext;
            MODE_SUB: a = x_al - lnf_ext;
            default:  a = x_al;
        endcase
    end

    // 1.0111b = 1 + 1/2 - 1/16; arithmetic shifts floor each partial product
    assign y     = a_q + (a_q >>> 1) - (a_q >>> 4);
    assign y_int = y[W-1:FRAC_W];

    always_comb begin
        ovf = !((y_int[DATA_W+1:DATA_W-1] == 3'b000) ||
                (y_int[DATA_W+1:DATA_W-1] == 3'b111));
        u   = y_int[DATA_W-1:0];
        v   = y[FRAC_W-1:0];
`ifdef EXP_PREPROC_SAT_EN
        if (ovf) begin
            if (y_int[DATA_W+1]) begin
                u = {1'b1, {(DATA_W-1){1'b0}}};
                v = '0;
            end else begin
                u = {1'b0, {(DATA_W-1){1'b1}}};
                v = '1;
            end
        end
`endif
    end

endmodule

// File: rtl/exp_preprocess_pipe.sv
// Two-stage valid/ready pipeline computing (X + s*lnF)*1.0111b per lane and
// splitting it into floor and fraction. Saturation option: EXP_PREPROC_SAT_EN.
module exp_preprocess_pipe
    import exp_preprocess_pipe_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W = FIXPOINT_FRAC,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         lnF,
    input  logic [LANES*DATA_W-1:0]   xi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   u,
    output logic [LANES*FRAC_W-1:0]   v,
    output logic [LANES-1:0]          ovf
);

    localparam int W = DATA_W + FRAC_W + 2;

    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s2_load;
    logic signed [W-1:0]     a_comb [LANES];
    logic signed [W-1:0]     s1_a   [LANES];
    logic [LANES*DATA_W-1:0] u_comb;
    logic [LANES*FRAC_W-1:0] v_comb;
    logic [LANES-1:0]        ovf_comb;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        exp_preproc_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .W      (W)
        ) u_lane (
            .x    (xi[k*DATA_W +: DATA_W]),
            .lnf  (lnF),
            .mode (mode),
            .a    (a_comb[k]),
            .a_q  (s1_a[k]),
            .u    (u_comb[k*DATA_W +: DATA_W]),
            .v    (v_comb[k*FRAC_W +: FRAC_W]),
            .ovf  (ovf_comb[k])
        );
    end

    // S1 can take a new beat whenever it is empty or is emptying into S2 this cycle
    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) s1_a[k] <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < LANES; k++) s1_a[k] <= a_comb[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            u        <= '0;
            v        <= '0;
            ovf      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                u   <= u_comb;
                v   <= v_comb;
                ovf <= ovf_comb;
            end
        end
    end

endmodule

// File: tb/tb_exp_preprocess_pipe.sv
// Directed, table-driven bench for exp_preprocess_pipe plus stall-stream and
// in-flight reset sequences; expectations are hand-computed constants.
module tb_exp_preprocess_pipe;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 10;
    localparam int LANES  = 4;
    localparam int NVEC   = 7;

    typedef struct {
        logic [1:0]   mode;
        logic [31:0]  lnf;
        logic [127:0] xi;
        logic [127:0] eu;
        logic [39:0]  ev;
        logic [3:0]   eovf;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              mode;
    logic [DATA_W-1:0]       lnF;
    logic [LANES*DATA_W-1:0] xi;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] u;
    logic [LANES*FRAC_W-1:0] v;
    logic [LANES-1:0]        ovf;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   passes = 0;

    // floor and fraction of i*1.4375 for lane0 of the stream test
    logic [31:0] stream_u [8] = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd7, 32'd8, 32'd10};
    logic [9:0]  stream_v [8] = '{10'd0, 10'd448, 10'd896, 10'd320, 10'd768, 10'd192, 10'd640, 10'd64};

    int           sent, recv, cyc, lat, stale;
    logic         held;
    logic [127:0] hold_u;
    logic [39:0]  hold_v;

    always #5 clk = ~clk;

    exp_preprocess_pipe #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .LANES  (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .lnF       (lnF),
        .xi        (xi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u         (u),
        .v         (v),
        .ovf       (ovf)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkValue(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic setVec(input int i, input logic [1:0] m, input logic [31:0] l,
                          input logic [127:0] x, input logic [127:0] eu,
                          input logic [39:0] ev, input logic [3:0] eo);
        vecs[i].mode = m;
        vecs[i].lnf  = l;
        vecs[i].xi   = x;
        vecs[i].eu   = eu;
        vecs[i].ev   = ev;
        vecs[i].eovf = eo;
    endtask

    // Drives one beat (called just after a rising edge) and waits for its result
    task automatic applyStimulus(input vec_t t, input string tag);
        mode     = t.mode;
        lnF      = t.lnf;
        xi       = t.xi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue({tag, ".latency"}, 128'(lat), 128'd1);
    endtask

    task automatic checkOutput(input vec_t t, input string tag);
        checkValue({tag, ".u"},   u,   t.eu);
        checkValue({tag, ".v"},   128'(v),   128'(t.ev));
        checkValue({tag, ".ovf"}, 128'(ovf), 128'(t.eovf));
    endtask

    initial begin
        setVec(0, 2'b00, 32'd0,
               {32'd1, 32'd0, 32'hFFFFFFFE, 32'd3},
               {32'd1, 32'd0, 32'hFFFFFFFD, 32'd4},
               {10'd448, 10'd0, 10'd128, 10'd320}, 4'b0000);
        setVec(1, 2'b10, 32'd1536,
               {32'd2, 32'hFFFFFFFF, 32'd0, 32'd5},
               {32'd0, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'd5},
               {10'd736, 10'd416, 10'd864, 10'd32}, 4'b0000);
        setVec(2, 2'b01, 32'd1536,
               {32'd2, 32'hFFFFFFFF, 32'd0, 32'd5},
               {32'd5, 32'd0, 32'd2, 32'd9},
               {10'd32, 10'd736, 10'd160, 10'd352}, 4'b0000);
        setVec(3, 2'b11, 32'd1536,
               {32'd1, 32'd0, 32'hFFFFFFFE, 32'd3},
               {32'd1, 32'd0, 32'hFFFFFFFD, 32'd4},
               {10'd448, 10'd0, 10'd128, 10'd320}, 4'b0000);
`ifdef EXP_PREPROC_SAT_EN
        setVec(4, 2'b00, 32'd0,
               {32'h60000000, 32'h50000000, 32'h80000000, 32'h7FFFFFFF},
               {32'h7FFFFFFF, 32'h73000000, 32'h80000000, 32'h7FFFFFFF},
               {10'd1023, 10'd0, 10'd0, 10'd1023}, 4'b1011);
`else
        setVec(4, 2'b00, 32'd0,
               {32'h60000000, 32'h50000000, 32'h80000000, 32'h7FFFFFFF},
               {32'h8A000000, 32'h73000000, 32'h48000000, 32'hB7FFFFFE},
               {10'd0, 10'd0, 10'd0, 10'd576}, 4'b1011);
`endif
        setVec(5, 2'b01, 32'hFFFFFE00,
               {32'd10, 32'd0, 32'hFFFFFFFF, 32'd1},
               {32'd13, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0},
               {10'd672, 10'd288, 10'd864, 10'd736}, 4'b0000);
        setVec(6, 2'b10, 32'd1,
               {32'd100, 32'hFFFFFFFF, 32'd1, 32'd0},
               {32'd143, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF},
               {10'd767, 10'd575, 10'd447, 10'd1023}, 4'b0000);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'b00;
        lnF       = '0;
        xi        = '0;
        #12;
        checkValue("reset.out_valid", 128'(out_valid), 128'd0);
        checkValue("reset.u", u, 128'd0);
        checkValue("reset.v", 128'(v), 128'd0);
        checkValue("reset.ovf", 128'(ovf), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkValue("reset.in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // Stream of 8 beats with out_ready cycling 1,0,0,1
        mode = 2'b00;
        lnF  = '0;
        sent = 0;
        recv = 0;
        cyc  = 0;
        held = 1'b0;
        while (recv < 8 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            xi        = {96'd0, 32'(sent)};
            @(negedge clk);
            if (held) begin
                checkValue("stall.valid", 128'(out_valid), 128'd1);
                checkValue("stall.u", u, hold_u);
                checkValue("stall.v", 128'(v), 128'(hold_v));
            end
            checkValue($sformatf("stream.in_ready.c%0d", cyc), 128'(in_ready),
                       128'(!((sent - recv) == 2 && !out_ready)));
            held   = out_valid && !out_ready;
            hold_u = u;
            hold_v = v;
            if (out_valid && out_ready) begin
                checkValue($sformatf("stream%0d.u", recv), 128'(u[31:0]), 128'(stream_u[recv]));
                checkValue($sformatf("stream%0d.v", recv), 128'(v[9:0]), 128'(stream_v[recv]));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkValue("stream.count", 128'(recv), 128'd8);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        xi        = {96'd0, 32'd7};
        @(posedge clk);
        #1;
        xi = {96'd0, 32'd6};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkValue("flight.out_valid_before", 128'(out_valid), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        checkValue("flight.out_valid", 128'(out_valid), 128'd0);
        checkValue("flight.u", u, 128'd0);
        checkValue("flight.v", 128'(v), 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        checkValue("flight.in_ready", 128'(in_ready), 128'd1);
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkValue("flight.stale", 128'(stale), 128'd0);
        @(posedge clk);
        #1;
        applyStimulus(vecs[2], "after_rst");
        checkOutput(vecs[2], "after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
